// File: rtl/l2_bus_controller_pkg.sv
// Shared encodings for the L2 shared-bus controller: bus operations,
// snoop results, FSM states and small op-classification helpers.
package l2_bus_controller_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_READ  = 3'd1,
    OP_WRITE = 3'd2,
    OP_INV   = 3'd3,
    OP_RWIM  = 3'd4
  } bus_op_e;

  typedef enum logic [1:0] {
    SNOOP_NOHIT = 2'd0,
    SNOOP_HIT   = 2'd1,
    SNOOP_HITM  = 2'd2
  } snoop_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_SNOOP   = 3'd2,
    ST_DATA    = 3'd3,
    ST_BACKOFF = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam int SNOOP_CNT_BITS = 4;
  localparam int RETRY_BITS     = 4;
  localparam logic [RETRY_BITS-1:0] RETRY_MAX = '1;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_READ) || (op == OP_WRITE) || (op == OP_INV) || (op == OP_RWIM);
  endfunction

  // Ops that bring a line back from the bus.
  function automatic logic op_is_fill(input logic [2:0] op);
    return (op == OP_READ) || (op == OP_RWIM);
  endfunction

endpackage

// File: rtl/l2_bus_controller_snoop_timer.sv
// Loadable down-counter: load with N, done is high on the Nth cycle after
// the load edge, marking the snoop-result sample cycle.
module snoop_timer
  import l2_bus_controller_pkg::*;
#(
  parameter int CW = SNOOP_CNT_BITS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  output logic          done
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == CW'(1));

endmodule

// File: rtl/l2_bus_controller.sv
// L2-side shared-bus master: address phase, snoop window, HITM backoff/retry,
// write or fill data phase, and a single-cycle completion pulse to the L2.
module l2_bus_controller
  import l2_bus_controller_pkg::*;
#(
  parameter int lineSize  = 512,
  parameter int addrBits  = 32,
  parameter int snoopWait = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [addrBits-1:0] req_addr,
  input  logic [lineSize-1:0] req_data,
  output logic [2:0]          bus_op,
  output logic [addrBits-1:0] bus_addr,
  output logic [lineSize-1:0] bus_data_out,
  output logic                bus_data_oe,
  input  logic [lineSize-1:0] bus_data_in,
  input  logic                mem_done,
  input  logic [1:0]          snoop_result,
  output logic                resp_valid,
  output logic [lineSize-1:0] resp_data,
  output logic                resp_shared
);

  state_e                  state, state_next;
  logic [2:0]              op_reg;
  logic [addrBits-1:0]     addr_reg;
  logic [lineSize-1:0]     data_reg;
  logic [lineSize-1:0]     fill_reg;
  logic                    shared_reg;
  logic [RETRY_BITS-1:0]   retry_cnt;
  logic                    accept;
  logic                    snoop_last;
  logic                    fill_op;
  logic                    snoop_hitm;

  assign accept     = req_valid && (state == ST_IDLE);
  assign fill_op    = op_is_fill(op_reg);
  assign snoop_hitm = (snoop_result == SNOOP_HITM);

  snoop_timer #(.CW(SNOOP_CNT_BITS)) u_snoop_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (state == ST_ADDR),
    .load_value (SNOOP_CNT_BITS'(snoopWait)),
    .done       (snoop_last)
  );

  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    bus_op      = '0;
    bus_addr    = '0;
    bus_data_oe = 1'b0;
    resp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        // Illegal ops complete immediately without touching the bus.
        if (req_valid) state_next = op_is_legal(req_op) ? ST_ADDR : ST_DONE;
      end
      ST_ADDR: begin
        bus_op     = op_reg;
        bus_addr   = addr_reg;
        state_next = ST_SNOOP;
      end
      ST_SNOOP: begin
        if (snoop_last) begin
          if (snoop_hitm && fill_op)  state_next = ST_BACKOFF;
          else if (op_reg == OP_INV)  state_next = ST_DONE;
          else                        state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        bus_data_oe = (op_reg == OP_WRITE);
        if (mem_done) state_next = ST_DONE;
      end
      ST_BACKOFF: begin
        if (mem_done) state_next = ST_ADDR;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_reg     <= '0;
      addr_reg   <= '0;
      data_reg   <= '0;
      fill_reg   <= '0;
      shared_reg <= 1'b0;
      retry_cnt  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_reg     <= req_op;
        addr_reg   <= req_addr;
        data_reg   <= req_data;
        fill_reg   <= '0;
        shared_reg <= 1'b0;
        retry_cnt  <= '0;
      end
      // Each attempt overwrites the sharing verdict, so only the final attempt counts.
      if (state == ST_SNOOP && snoop_last) begin
        shared_reg <= (op_reg == OP_READ) &&
                      (snoop_result == SNOOP_HIT || snoop_result == SNOOP_HITM);
      end
      if (state == ST_DATA && mem_done && fill_op) begin
        fill_reg <= bus_data_in;
      end
      if (state == ST_BACKOFF && mem_done && retry_cnt != RETRY_MAX) begin
        retry_cnt <= retry_cnt + 1'b1;
      end
    end
  end

  assign bus_data_out = bus_data_oe ? data_reg : '0;
  assign resp_data    = fill_reg;
  assign resp_shared  = shared_reg;

endmodule

// File: tb/tb_l2_bus_controller.sv
// Scoreboard bench for l2_bus_controller: a driver issues requests and queues
// expected responses, a bus agent plays snoop/memory, a monitor checks outputs.
`timescale 1ns/1ps
module tb_l2_bus_controller;
  import l2_bus_controller_pkg::*;

  localparam int LS = 512;
  localparam int AB = 32;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic [AB-1:0] req_addr = '0;
  logic [LS-1:0] req_data = '0;
  logic [2:0]    bus_op;
  logic [AB-1:0] bus_addr;
  logic [LS-1:0] bus_data_out;
  logic          bus_data_oe;
  logic [LS-1:0] bus_data_in;
  logic          mem_done;
  logic [1:0]    snoop_result;
  logic          resp_valid;
  logic [LS-1:0] resp_data;
  logic          resp_shared;

  always #5 clk = ~clk;

  l2_bus_controller #(.lineSize(LS), .addrBits(AB), .snoopWait(SW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .bus_op(bus_op), .bus_addr(bus_addr), .bus_data_out(bus_data_out),
    .bus_data_oe(bus_data_oe), .bus_data_in(bus_data_in), .mem_done(mem_done),
    .snoop_result(snoop_result), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_shared(resp_shared)
  );

  typedef struct {
    logic [2:0]    op;
    logic [AB-1:0] addr;
    logic [LS-1:0] data;
    logic [LS-1:0] rdata;
    logic          shared;
    int            n_addr;
    int            lat;
    int            oe_cycles;
  } exp_t;

  typedef struct {
    logic [1:0]    snoop;
    int            d;
    bit            spurious;
    bit            mem;
    logic [LS-1:0] line;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    checks = 0;
  int    errors = 0;

  // Per-attempt stimulus staged by the driver before each send().
  logic [1:0] att_snoop [0:19];
  int         att_d     [0:19];
  bit         att_spur  [0:19];

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_line(input string name, input logic [LS-1:0] act, input logic [LS-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic flag_fail(input string name, input string why);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, why);
  endtask

  function automatic logic [LS-1:0] rand_line();
    logic [LS-1:0] v;
    for (int i = 0; i < LS / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: derive attempts, latency, fill and sharing from the bus rules.
  task automatic send(input logic [2:0] op, input logic [AB-1:0] addr, input logic [LS-1:0] data);
    exp_t  e;
    plan_t p;
    int    o;
    int    n;
    bit    fill;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    n = 0;
    while (!req_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      flag_fail("accept_timeout", "request never accepted");
      return;
    end
    e.op = op; e.addr = addr; e.data = data;
    e.rdata = '0; e.shared = 1'b0; e.oe_cycles = 0; e.n_addr = 0; e.lat = 1;
    fill = (op == OP_READ) || (op == OP_RWIM);
    if (op == OP_READ || op == OP_WRITE || op == OP_INV || op == OP_RWIM) begin
      o = 1;
      for (int i = 0; i < 20; i++) begin
        p.snoop = att_snoop[i]; p.d = att_d[i]; p.spurious = att_spur[i];
        p.line = rand_line();
        e.n_addr++;
        if (fill && p.snoop == SNOOP_HITM) begin
          p.mem = 1'b1;
          o += SW + 2 + p.d;
          plan_q.push_back(p);
        end else begin
          if (op == OP_INV) begin
            p.mem = 1'b0;
            e.lat = o + SW + 1;
          end else begin
            p.mem = 1'b1;
            e.lat = o + SW + 2 + p.d;
            if (op == OP_WRITE) e.oe_cycles = p.d + 1;
            else                e.rdata = p.line;
          end
          e.shared = (op == OP_READ) && (p.snoop == SNOOP_HIT || p.snoop == SNOOP_HITM);
          plan_q.push_back(p);
          break;
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      flag_fail("drain_timeout", "response never arrived");
      exp_q.delete();
      plan_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_att(input int i, input logic [1:0] s, input int d, input bit sp);
    att_snoop[i] = s; att_d[i] = d; att_spur[i] = sp;
  endtask

  // Bus agent: answers each address phase with the planned snoop and memory timing.
  initial begin
    plan_t p;
    int    k;
    mem_done = 1'b0; snoop_result = 2'd0; bus_data_in = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus_op != 3'd0 && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        @(posedge clk); #1;
        snoop_result = p.snoop;
        bus_data_in  = rand_line();
        k = 1;
        if (p.spurious) begin
          mem_done = 1'b1;
          @(posedge clk); #1;
          mem_done = 1'b0;
          k = 2;
        end
        if (p.mem) begin
          while (k < SW + 1 + p.d) begin
            @(posedge clk); #1;
            k++;
          end
          mem_done = 1'b1; bus_data_in = p.line;
          @(posedge clk); #1;
          mem_done = 1'b0; bus_data_in = rand_line();
        end
      end
    end
  end

  // Monitor: mid-cycle sampling of every DUT output against the queue head.
  initial begin
    exp_t e;
    int cyc, acc_cyc, n_addr, oe_cnt;
    cyc = 0; acc_cyc = 0; n_addr = 0; oe_cnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (req_valid && req_ready) begin
          chk_int("accept_in_done", int'(resp_valid), 0);
          acc_cyc = cyc; n_addr = 0; oe_cnt = 0;
        end
        if (bus_op != 3'd0) begin
          n_addr++;
          if (exp_q.size() == 0) flag_fail("addr_unexpected", "address phase with nothing outstanding");
          else begin
            chk_int("bus_op", int'(bus_op), int'(exp_q[0].op));
            chk_int("bus_addr", int'(bus_addr), int'(exp_q[0].addr));
            chk_int("oe_in_addr", int'(bus_data_oe), 0);
          end
        end
        if (bus_data_oe) begin
          oe_cnt++;
          if (exp_q.size() == 0) flag_fail("oe_unexpected", "oe with nothing outstanding");
          else begin
            chk_int("oe_on_write", int'(exp_q[0].op == OP_WRITE), 1);
            chk_line("bus_data_out", bus_data_out, exp_q[0].data);
          end
        end
        if (resp_valid) begin
          if (exp_q.size() == 0) flag_fail("resp_unexpected", "resp_valid with nothing outstanding");
          else begin
            e = exp_q.pop_front();
            chk_line("resp_data", resp_data, e.rdata);
            chk_int("resp_shared", int'(resp_shared), int'(e.shared));
            chk_int("addr_phases", n_addr, e.n_addr);
            chk_int("latency", cyc - acc_cyc, e.lat);
            chk_int("oe_cycles", oe_cnt, e.oe_cycles);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]    op;
    logic [AB-1:0] addr;
    int            nr;
    int            n;
    bit            b2b;

    repeat (3) @(posedge clk);
    #1;
    chk_int("rst_req_ready", int'(req_ready), 1);
    chk_int("rst_bus_op", int'(bus_op), 0);
    chk_int("rst_bus_addr", int'(bus_addr), 0);
    chk_int("rst_oe", int'(bus_data_oe), 0);
    chk_int("rst_resp_valid", int'(resp_valid), 0);
    chk_int("rst_resp_shared", int'(resp_shared), 0);
    chk_line("rst_resp_data", resp_data, '0);
    chk_line("rst_bus_data_out", bus_data_out, '0);
    chk_int("rst_retry", int'(dut.retry_cnt), 0);
    @(negedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;

    // READ with NOHIT, fill of A5 bytes.
    set_att(0, SNOOP_NOHIT, 4, 0);
    send(OP_READ, 32'h0000_1240, '0);
    req_valid = 1'b0;
    plan_q[plan_q.size()-1].line = {(LS/8){8'hA5}};
    exp_q[exp_q.size()-1].rdata  = {(LS/8){8'hA5}};
    drain();

    // READ with HITM, peer writeback, reissue with HIT.
    set_att(0, SNOOP_HITM, 2, 0);
    set_att(1, SNOOP_HIT, 1, 0);
    send(OP_READ, 32'h0000_2000, '0);
    req_valid = 1'b0;
    drain();
    chk_int("retry_one", int'(dut.retry_cnt), 1);

    // WRITE with mem_done three cycles into the data phase.
    set_att(0, SNOOP_NOHIT, 3, 0);
    send(OP_WRITE, 32'h0000_3040, {(LS/32){32'h1234_5678}});
    req_valid = 1'b0;
    drain();

    // INVALIDATE: response in cycle SW+2 after the acceptance cycle (the SW+3th cycle).
    set_att(0, SNOOP_HIT, 0, 1);
    send(OP_INV, 32'h0000_4080, '0);
    req_valid = 1'b0;
    drain();

    // Back-to-back: req_valid held through DONE.
    set_att(0, SNOOP_NOHIT, 0, 0);
    send(OP_INV, 32'h0000_5000, '0);
    set_att(0, SNOOP_HIT, 2, 0);
    send(OP_READ, 32'h0000_5040, '0);
    req_valid = 1'b0;
    drain();

    // Illegal op completes with no bus activity.
    set_att(0, SNOOP_NOHIT, 0, 0);
    send(3'd6, 32'h0000_6000, rand_line());
    req_valid = 1'b0;
    drain();

    // Retry counter saturation: 17 HITM backoffs before a clean snoop.
    for (int i = 0; i < 17; i++) set_att(i, SNOOP_HITM, 0, 0);
    set_att(17, SNOOP_NOHIT, 0, 0);
    send(OP_RWIM, 32'h0000_7000, '0);
    req_valid = 1'b0;
    drain();
    chk_int("retry_saturate", int'(dut.retry_cnt), 15);

    // Randomized traffic.
    for (int t = 0; t < 120; t++) begin
      if ($urandom_range(0, 99) < 8) begin
        case ($urandom_range(0, 3))
          0:       op = 3'd0;
          1:       op = 3'd5;
          2:       op = 3'd6;
          default: op = 3'd7;
        endcase
      end else begin
        op = 3'($urandom_range(1, 4));
      end
      addr = $urandom & 32'hFFFF_FFC0;
      nr = 0;
      if ((op == OP_READ || op == OP_RWIM) && $urandom_range(0, 3) == 0) nr = $urandom_range(1, 3);
      for (int i = 0; i < nr; i++) set_att(i, SNOOP_HITM, $urandom_range(0, 4), $urandom_range(0, 1));
      if (op == OP_READ || op == OP_RWIM) set_att(nr, 2'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 1));
      else set_att(nr, 2'($urandom_range(0, 2)), $urandom_range(0, 5), $urandom_range(0, 1));
      send(op, addr, rand_line());
      b2b = ($urandom_range(0, 2) == 0);
      if (!b2b) begin
        req_valid = 1'b0;
        drain();
      end
    end
    req_valid = 1'b0;
    drain();
    chk_int("plans_left", plan_q.size(), 0);

    // Reset in the middle of a WRITE data phase.
    set_att(0, SNOOP_NOHIT, 10, 0);
    send(OP_WRITE, 32'h0000_8000, rand_line());
    req_valid = 1'b0;
    n = 0;
    while (!bus_data_oe && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk_int("oe_before_reset", int'(bus_data_oe), 1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk_int("oe_async_drop", int'(bus_data_oe), 0);
    chk_int("ready_in_reset", int'(req_ready), 1);
    chk_line("data_out_in_reset", bus_data_out, '0);
    exp_q.delete();
    plan_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk_int("no_resp_after_reset", int'(resp_valid), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
